rv_iommu_axi4_burst_splitter: RTL

- Initiator-side counterpart to the IOMMU's AXI4 4-KiB boundary checking.
- Takes a linear read request (start address, total beat count, beat size) and issues a sequence of AXI4 INCR AR requests.
- No issued request crosses a 4-KiB boundary, and none exceeds 256 beats.
- Sits in front of the IOMMU's AXI master port, for example for PTW and CQ/FQ fetches, so everything it emits passes the boundary check by construction.

---
 rtl/rv_iommu_axi4_burst_splitter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rv_iommu_axi4_burst_splitter.sv
// Splits a linear read request into AXI4 INCR AR bursts that never cross 4 KiB or exceed 256 beats.
// Optional split statistics (split_cnt_o, split_o) are enabled with RV_IOMMU_AXI4_SPLIT_STATS_EN.
module rv_iommu_axi4_burst_splitter #(
  parameter int ADDR_WIDTH = 56,
  parameter int NBEATS_W   = 12,
  parameter int MAX_SIZE   = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NBEATS_W-1:0]   req_nbeats_i,
  input  logic [2:0]            req_size_i,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  output logic [7:0]            ar_len_o,
  output logic [2:0]            ar_size_o,
  output logic [1:0]            ar_burst_o,
  output logic                  ar_last_o,
  output logic                  done_o,
  output logic                  err_o
`ifdef RV_IOMMU_AXI4_SPLIT_STATS_EN
  ,
  output logic [7:0]            split_cnt_o,
  output logic                  split_o
`endif
);

  typedef enum logic {IDLE, ISSUE} state_e;

  localparam int EW = ADDR_WIDTH + NBEATS_W + 8;
  localparam int CW = (NBEATS_W > 13) ? NBEATS_W : 13;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NBEATS_W-1:0]   rem_q, rem_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            len_q, len_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [EW-1:0]         end_addr;
  logic [7:0]            align_mask;
  logic                  req_bad;
  logic [12:0]           chunk_cur, chunk_n;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [NBEATS_W-1:0]   rem_nx;

  // Beats to issue from addr offset off: min(remaining, beats to 4 KiB edge, 256).
  function automatic logic [12:0] calc_chunk(input logic [11:0] off,
                                             input logic [NBEATS_W-1:0] rem,
                                             input logic [2:0] size);
    logic [CW-1:0] to_bnd;
    logic [CW-1:0] c;
    to_bnd = CW'((13'd4096 - {1'b0, off}) >> size);
    c = to_bnd;
    if (CW'(rem) < c) c = CW'(rem);
    if (c > CW'(256)) c = CW'(256);
    return 13'(c);
  endfunction

  always_comb begin
    end_addr   = EW'(req_addr_i) + (EW'(req_nbeats_i) << req_size_i) - EW'(1);
    align_mask = (8'd1 << req_size_i) - 8'd1;
    req_bad    = (req_nbeats_i == '0) || (req_size_i > 3'(MAX_SIZE)) ||
                 (|(req_addr_i[7:0] & align_mask)) || (|end_addr[EW-1:ADDR_WIDTH]);
    chunk_cur  = 13'(len_q) + 13'd1;
    addr_nx    = addr_q + (ADDR_WIDTH'(chunk_cur) << size_q);
    rem_nx     = rem_q - NBEATS_W'(chunk_cur);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    size_d  = size_q;
    len_d   = len_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    chunk_n = '0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            chunk_n = calc_chunk(req_addr_i[11:0], req_nbeats_i, req_size_i);
            addr_d  = req_addr_i;
            rem_d   = req_nbeats_i;
            size_d  = req_size_i;
            len_d   = 8'(chunk_n - 13'd1);
            last_d  = (CW'(chunk_n) == CW'(req_nbeats_i));
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (ar_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            chunk_n = calc_chunk(addr_nx[11:0], rem_nx, size_q);
            addr_d  = addr_nx;
            rem_d   = rem_nx;
            len_d   = 8'(chunk_n - 13'd1);
            last_d  = (CW'(chunk_n) == CW'(rem_nx));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      size_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      size_q  <= size_d;
      len_q   <= len_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign ar_valid_o  = (state_q == ISSUE);
  assign ar_addr_o   = addr_q;
  assign ar_len_o    = len_q;
  assign ar_size_o   = size_q;
  assign ar_burst_o  = 2'b01;
  assign ar_last_o   = last_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

`ifdef RV_IOMMU_AXI4_SPLIT_STATS_EN
  logic [7:0] split_cnt_q, split_cnt_d;
  logic       split_q, split_d;

  // A non-zero count before the final handshake means more than one AR was needed.
  always_comb begin
    split_cnt_d = split_cnt_q;
    split_d     = 1'b0;
    if (state_q == IDLE && req_valid_i && !req_bad) begin
      split_cnt_d = '0;
    end else if (state_q == ISSUE && ar_ready_i) begin
      if (split_cnt_q != 8'hFF) split_cnt_d = split_cnt_q + 8'd1;
      if (last_q) split_d = (split_cnt_q != 8'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      split_cnt_q <= '0;
      split_q     <= 1'b0;
    end else begin
      split_cnt_q <= split_cnt_d;
      split_q     <= split_d;
    end
  end

  assign split_cnt_o = split_cnt_q;
  assign split_o     = split_q;
`endif

endmodule
